// File: rtl/minilcd_vram_arb.sv
// minilcd_vram_arb: sole write master of the MiniLCD VRAM. It arbitrates the
// single VRAM write port between CPU pixel writes and a rectangle-fill engine,
// using round-robin when both want the port. The engine is a two-state FSM
// with x/y scan counters.
// Optional build macro: MINILCD_FILL_CLIP_EN. When it is defined, a rectangle
// is clipped at the right and bottom screen edges. When it is undefined, the
// rectangle wraps around the screen modulo 2**CW.
module minilcd_vram_arb #(
    parameter int CW = 7,
    parameter int DW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CPU_REQ,
    input  logic [2*CW-1:0] CPU_ADDR,
    input  logic [DW-1:0]   CPU_DATA,
    output logic            CPU_ACK,
    input  logic            FILL_START,
    input  logic [CW-1:0]   FILL_X0,
    input  logic [CW-1:0]   FILL_Y0,
    input  logic [CW:0]     FILL_W,
    input  logic [CW:0]     FILL_H,
    input  logic [DW-1:0]   FILL_COLOR,
    output logic            FILL_BUSY,
    output logic            FILL_DONE,
    output logic [2*CW-1:0] VRAM_ADDR,
    output logic [DW-1:0]   VRAM_DATA,
    output logic            VRAM_WE
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [CW:0] SCREEN = {1'b1, {CW{1'b0}}};
    localparam logic [CW:0] ONE    = {{CW{1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [CW-1:0] x0, y0;
    logic [CW:0]   w, h;
    logic [DW-1:0] color;
    logic [CW:0]   xi, yj;
    logic          rr_cpu_last;   // 1: CPU won the last grant, so the fill goes first next

    logic [CW:0]   w_sat, h_sat, w_eff, h_eff;
    logic          start_ok, start_zero, start_go;
    logic          last_col, last_row, last_px;
    logic          cpu_grant, fill_grant;
    logic [CW-1:0] px, py;

    // Saturate the requested size to the screen size, then clip it if that build option is on.
    always_comb begin
        w_sat = (FILL_W > SCREEN) ? SCREEN : FILL_W;
        h_sat = (FILL_H > SCREEN) ? SCREEN : FILL_H;
`ifdef MINILCD_FILL_CLIP_EN
        w_eff = (w_sat > SCREEN - {1'b0, FILL_X0}) ? SCREEN - {1'b0, FILL_X0} : w_sat;
        h_eff = (h_sat > SCREEN - {1'b0, FILL_Y0}) ? SCREEN - {1'b0, FILL_Y0} : h_sat;
`else
        w_eff = w_sat;
        h_eff = h_sat;
`endif
    end

    assign start_ok   = (state == IDLE) && FILL_START;
    assign start_zero = start_ok && ((w_eff == '0) || (h_eff == '0));
    assign start_go   = start_ok && !start_zero;

    assign last_col = (xi == w - ONE);
    assign last_row = (yj == h - ONE);
    assign last_px  = last_col && last_row;

    // The coordinate adds truncate to CW bits. Without clipping, this gives the screen wrap.
    assign px = x0 + xi[CW-1:0];
    assign py = y0 + yj[CW-1:0];

    // CPU wins when the port is idle, or when the fill engine won the previous contended grant.
    assign cpu_grant  = !RST && CPU_REQ && ((state == IDLE) || !rr_cpu_last);
    assign fill_grant = (state == FILL) && !cpu_grant;

    assign CPU_ACK   = cpu_grant;
    assign FILL_BUSY = (state == FILL);

    // Next-state logic: start on a non-empty fill, and stop once the last pixel is granted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = FILL;
            FILL:    if (fill_grant && last_px) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the fill parameters, and step the row-major scan counters on each fill grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            color <= '0;
            xi    <= '0;
            yj    <= '0;
        end else if (start_go) begin
            x0    <= FILL_X0;
            y0    <= FILL_Y0;
            w     <= w_eff;
            h     <= h_eff;
            color <= FILL_COLOR;
            xi    <= '0;
            yj    <= '0;
        end else if (fill_grant) begin
            if (last_col) begin
                xi <= '0;
                yj <= yj + ONE;
            end else begin
                xi <= xi + ONE;
            end
        end
    end

    // Round-robin flag: remember which source won the most recent grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)             rr_cpu_last <= 1'b1;
        else if (cpu_grant)  rr_cpu_last <= 1'b1;
        else if (fill_grant) rr_cpu_last <= 1'b0;
    end

    // Register the granted write onto the VRAM port. DONE lines up with the last fill write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            VRAM_WE   <= 1'b0;
            VRAM_ADDR <= '0;
            VRAM_DATA <= '0;
            FILL_DONE <= 1'b0;
        end else begin
            VRAM_WE   <= cpu_grant || fill_grant;
            FILL_DONE <= start_zero || (fill_grant && last_px);
            if (cpu_grant) begin
                VRAM_ADDR <= CPU_ADDR;
                VRAM_DATA <= CPU_DATA;
            end else if (fill_grant) begin
                VRAM_ADDR <= {py, px};
                VRAM_DATA <= color;
            end
        end
    end

endmodule
